// File: rtl/lab1_imul_int_mul_param.sv
// Iterative shift-add multiplier with a val/rdy stream interface and a
// double-width product. It handles signed and unsigned operands and stops as soon as the remaining multiplier bits are zero.

module lab1_imul_int_mul_param_chk #(
    parameter int p_nbits = 32,
    parameter int CW      = 6
) (
    input logic                   clk,
    input logic                   reset,
    input logic [CW-1:0]          iter_cnt,
    input logic                   ostream_val,
    input logic                   ostream_rdy,
    input logic [2*p_nbits-1:0]   ostream_msg
);

    localparam logic [CW-1:0] CNT_LIMIT = CW'(p_nbits + 1);

    a_cnt_bound: assert property (@(posedge clk) disable iff (reset)
        iter_cnt <= CNT_LIMIT);

    // A stalled response must hold both valid and the product.
    a_resp_stable: assert property (@(posedge clk) disable iff (reset)
        (ostream_val && !ostream_rdy) |=> (ostream_val && $stable(ostream_msg)));

endmodule

module lab1_imul_int_mul_param #(
    parameter int p_nbits = 32
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   istream_val,
    output logic                   istream_rdy,
    input  logic [2*p_nbits:0]     istream_msg,
    output logic                   ostream_val,
    input  logic                   ostream_rdy,
    output logic [2*p_nbits-1:0]   ostream_msg
);

    localparam int NW = 2 * p_nbits;
    localparam int CW = $clog2(p_nbits + 2);
    localparam logic [CW-1:0] CNT_LIMIT = CW'(p_nbits + 1);
    localparam logic [CW-1:0] CNT_ONE   = {{(CW-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    state_e               state_q, state_d;
    logic [NW-1:0]        areg_q, areg_d;
    logic [NW-1:0]        result_q, result_d;
    logic [p_nbits-1:0]   breg_q, breg_d;
    logic                 neg_q, neg_d;
    logic [CW-1:0]        cnt_q, cnt_d;

    logic                 sgn_s;
    logic [p_nbits-1:0]   a_s, b_s;
    logic [p_nbits-1:0]   a_mag_s, b_mag_s;
    logic                 accept_s, resp_hs_s;

    // Magnitude as an N-bit unsigned value, so the most negative operand maps to 2^(N-1).
    function automatic logic [p_nbits-1:0] op_mag(input logic [p_nbits-1:0] v, input logic sgn);
        if (sgn && v[p_nbits-1]) begin
            return ~v + {{(p_nbits-1){1'b0}}, 1'b1};
        end else begin
            return v;
        end
    endfunction

    function automatic logic [NW-1:0] neg2(input logic [NW-1:0] v);
        return ~v + {{(NW-1){1'b0}}, 1'b1};
    endfunction

    assign sgn_s     = istream_msg[NW];
    assign a_s       = istream_msg[NW-1:p_nbits];
    assign b_s       = istream_msg[p_nbits-1:0];
    assign a_mag_s   = op_mag(a_s, sgn_s);
    assign b_mag_s   = op_mag(b_s, sgn_s);

    assign istream_rdy = (state_q == ST_IDLE) & ~reset;
    assign ostream_val = (state_q == ST_DONE);
    assign ostream_msg = result_q;

    assign accept_s  = istream_val & istream_rdy;
    assign resp_hs_s = ostream_val & ostream_rdy;

    // Next-state and datapath update for the accept / iterate / hold phases.
    always_comb begin
        state_d  = state_q;
        areg_d   = areg_q;
        breg_d   = breg_q;
        result_d = result_q;
        neg_d    = neg_q;
        cnt_d    = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (accept_s) begin
                    state_d  = ST_CALC;
                    areg_d   = {{p_nbits{1'b0}}, a_mag_s};
                    breg_d   = b_mag_s;
                    neg_d    = sgn_s & (a_s[p_nbits-1] ^ b_s[p_nbits-1]);
                    result_d = {NW{1'b0}};
                    cnt_d    = {CW{1'b0}};
                end else begin
                    state_d  = ST_IDLE;
                end
            end
            ST_CALC: begin
                // The counter limit is a guard only; legal operands empty breg first.
                if ((breg_q == {p_nbits{1'b0}}) || (cnt_q == CNT_LIMIT)) begin
                    result_d = neg_q ? neg2(result_q) : result_q;
                    state_d  = ST_DONE;
                end else begin
                    if (breg_q[0]) begin
                        result_d = result_q + areg_q;
                    end else begin
                        result_d = result_q;
                    end
                    areg_d  = areg_q << 1;
                    breg_d  = breg_q >> 1;
                    cnt_d   = cnt_q + CNT_ONE;
                    state_d = ST_CALC;
                end
            end
            ST_DONE: begin
                if (resp_hs_s) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_DONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers; reset discards any in-flight transaction.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            areg_q   <= {NW{1'b0}};
            breg_q   <= {p_nbits{1'b0}};
            result_q <= {NW{1'b0}};
            neg_q    <= 1'b0;
            cnt_q    <= {CW{1'b0}};
        end else begin
            state_q  <= state_d;
            areg_q   <= areg_d;
            breg_q   <= breg_d;
            result_q <= result_d;
            neg_q    <= neg_d;
            cnt_q    <= cnt_d;
        end
    end

    lab1_imul_int_mul_param_chk #(
        .p_nbits (p_nbits),
        .CW      (CW)
    ) u_chk (
        .clk         (clk),
        .reset       (reset),
        .iter_cnt    (cnt_q),
        .ostream_val (ostream_val),
        .ostream_rdy (ostream_rdy),
        .ostream_msg (ostream_msg)
    );

endmodule

// File: tb/tb_lab1_imul_int_mul_param.sv
// Scoreboard bench for lab1_imul_int_mul_param at N = 32, 8 and 16: stimulus
// pushes arithmetic-model expectations, a negedge monitor pops and compares.

module tb_lab1_imul_int_mul_param;

    logic clk, reset;

    logic        ival0, irdy0, oval0, ordy0;
    logic [64:0] imsg0;
    logic [63:0] omsg0;
    logic        ival1, irdy1, oval1, ordy1;
    logic [16:0] imsg1;
    logic [15:0] omsg1;
    logic        ival2, irdy2, oval2, ordy2;
    logic [32:0] imsg2;
    logic [31:0] omsg2;

    typedef struct {
        logic [63:0] prod;
        int          t_exp;
    } exp_t;

    exp_t sb_q [3][$];
    int   n_cmp = 0;
    int   n_err = 0;
    int   n_timeout = 0;
    int   cyc = 0;
    int   sink_mode = 0;
    bit   fin_req = 1'b0;
    logic rst_q = 1'b0;
    bit   seen_rise [3];
    bit   after_hs  [3];

    lab1_imul_int_mul_param #(.p_nbits(32)) u_dut32 (
        .clk(clk), .reset(reset),
        .istream_val(ival0), .istream_rdy(irdy0), .istream_msg(imsg0),
        .ostream_val(oval0), .ostream_rdy(ordy0), .ostream_msg(omsg0));

    lab1_imul_int_mul_param #(.p_nbits(8)) u_dut8 (
        .clk(clk), .reset(reset),
        .istream_val(ival1), .istream_rdy(irdy1), .istream_msg(imsg1),
        .ostream_val(oval1), .ostream_rdy(ordy1), .ostream_msg(omsg1));

    lab1_imul_int_mul_param #(.p_nbits(16)) u_dut16 (
        .clk(clk), .reset(reset),
        .istream_val(ival2), .istream_rdy(irdy2), .istream_msg(imsg2),
        .ostream_val(oval2), .ostream_rdy(ordy2), .ostream_msg(omsg2));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) begin
        cyc   <= cyc + 1;
        rst_q <= reset;
    end

    function automatic int nb(int sel);
        case (sel)
            0:       return 32;
            1:       return 8;
            default: return 16;
        endcase
    endfunction

    function automatic logic [31:0] mask_n(int n);
        if (n >= 32) return 32'hFFFF_FFFF;
        else return (32'd1 << n) - 32'd1;
    endfunction

    // Reference model: plain integer arithmetic on sign- or zero-extended values.
    function automatic longint ext(int n, bit sgn, logic [31:0] v);
        longint x;
        x = longint'({32'd0, v & mask_n(n)});
        if (sgn) begin
            x = x << (64 - n);
            x = x >>> (64 - n);
        end
        return x;
    endfunction

    function automatic logic [63:0] ref_prod(int n, bit sgn, logic [31:0] a, logic [31:0] b);
        logic [63:0] p, m;
        p = 64'(ext(n, sgn, a) * ext(n, sgn, b));
        m = (n >= 32) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << (2 * n)) - 64'd1);
        return p & m;
    endfunction

    function automatic int ref_bitlen(int n, bit sgn, logic [31:0] b);
        longint mag;
        int k;
        mag = ext(n, sgn, b);
        if (mag < 0) mag = -mag;
        k = 0;
        while (mag != 0) begin
            mag = mag >> 1;
            k++;
        end
        return k;
    endfunction

    function automatic logic [31:0] pick(int n);
        logic [31:0] v;
        case ($urandom_range(0, 5))
            0:       v = 32'd1 << (n - 1);
            1:       v = 32'hFFFF_FFFF;
            2:       v = 32'd0;
            default: v = $urandom >> $urandom_range(0, 31);
        endcase
        return v & mask_n(n);
    endfunction

    function automatic logic rdy_of(int sel);
        case (sel)
            0:       return irdy0;
            1:       return irdy1;
            default: return irdy2;
        endcase
    endfunction

    task automatic drive(int sel, logic v, logic [64:0] m);
        case (sel)
            0:       begin ival0 = v; imsg0 = m;        end
            1:       begin ival1 = v; imsg1 = m[16:0];  end
            default: begin ival2 = v; imsg2 = m[32:0];  end
        endcase
    endtask

    // Called at posedge+1; returns at posedge+1 of the cycle after acceptance.
    task automatic send(int sel, bit sgn, logic [31:0] a, logic [31:0] b);
        int n;
        int w;
        logic [64:0] m;
        exp_t e;
        n = nb(sel);
        m = (65'(sgn) << (2 * n)) | (65'(a & mask_n(n)) << n) | 65'(b & mask_n(n));
        drive(sel, 1'b1, m);
        w = 0;
        @(negedge clk);
        while (!rdy_of(sel) && w < 100) begin
            @(negedge clk);
            w++;
        end
        if (!rdy_of(sel)) begin
            n_timeout++;
        end else begin
            e.prod  = ref_prod(n, sgn, a, b);
            e.t_exp = cyc + ref_bitlen(n, sgn, b) + 2;
            sb_q[sel].push_back(e);
        end
        @(posedge clk);
        #1;
        drive(sel, 1'b0, 65'({$urandom, $urandom}));
    endtask

    task automatic wait_idle(int sel);
        int w;
        w = 0;
        while (sb_q[sel].size() != 0 && w < 400) begin
            @(posedge clk);
            w++;
        end
        #1;
        if (sb_q[sel].size() != 0) n_timeout++;
    endtask

    function automatic bit sink_bit();
        case (sink_mode)
            0:       return 1'b1;
            1:       return ($urandom_range(0, 2) != 0);
            default: return 1'b0;
        endcase
    endfunction

    initial begin
        ordy0 = 1'b1; ordy1 = 1'b1; ordy2 = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            ordy0 = sink_bit();
            ordy1 = sink_bit();
            ordy2 = sink_bit();
        end
    end

    task automatic chk(int sel, string name, logic [63:0] act, logic [63:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s [N=%0d] at cycle %0d: actual=%0h required=%0h",
                     name, nb(sel), cyc, act, req);
        end
    endtask

    task automatic mon(int sel, logic oval, logic ordy, logic irdy, logic [63:0] omsg);
        exp_t e;
        if (reset && rst_q) begin
            chk(sel, "reset_istream_rdy", 64'(irdy), 64'd0);
            chk(sel, "reset_ostream_val", 64'(oval), 64'd0);
            chk(sel, "reset_ostream_msg", omsg, 64'd0);
            sb_q[sel].delete();
            seen_rise[sel] = 1'b0;
            after_hs[sel]  = 1'b0;
        end else begin
            if (!reset && rst_q) chk(sel, "rdy_after_reset", 64'(irdy), 64'd1);
            if (after_hs[sel] && !reset) chk(sel, "rdy_after_resp", 64'(irdy), 64'd1);
            after_hs[sel] = 1'b0;
            if (oval) begin
                if (sb_q[sel].size() == 0) begin
                    chk(sel, "unexpected_resp", 64'(oval), 64'd0);
                end else begin
                    e = sb_q[sel][0];
                    if (!seen_rise[sel]) begin
                        chk(sel, "latency_cycle", 64'(cyc), 64'(e.t_exp));
                        seen_rise[sel] = 1'b1;
                    end
                    chk(sel, "product", omsg, e.prod);
                    chk(sel, "rdy_while_busy", 64'(irdy), 64'd0);
                    if (ordy) begin
                        void'(sb_q[sel].pop_front());
                        seen_rise[sel] = 1'b0;
                        after_hs[sel]  = 1'b1;
                    end
                end
            end else if (seen_rise[sel]) begin
                chk(sel, "val_dropped_in_stall", 64'(oval), 64'd1);
                seen_rise[sel] = 1'b0;
            end
        end
    endtask

    always @(negedge clk) begin
        mon(0, oval0, ordy0, irdy0, omsg0);
        mon(1, oval1, ordy1, irdy1, 64'(omsg1));
        mon(2, oval2, ordy2, irdy2, 64'(omsg2));
        if (fin_req || cyc > 60000) begin
            chk(0, "watchdog", 64'(cyc > 60000), 64'd0);
            chk(0, "handshake_timeouts", 64'(n_timeout), 64'd0);
            for (int s = 0; s < 3; s++) chk(s, "pending_responses", 64'(sb_q[s].size()), 64'd0);
            $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
            $finish;
        end
    end

    logic [64:0] dir_v [8];

    initial begin
        dir_v = '{
            {1'b0, 32'd3,          32'd5},
            {1'b0, 32'hFFFF_FFFF,  32'hFFFF_FFFF},
            {1'b1, 32'hFFFF_FFFD,  32'd5},
            {1'b1, 32'd7,          32'hFFFF_FFFF},
            {1'b1, 32'h8000_0000,  32'h8000_0000},
            {1'b1, 32'hFFFF_FFFF,  32'hFFFF_FFFF},
            {1'b0, 32'h0000_1234,  32'd0},
            {1'b0, 32'd0,          32'h8000_0000}
        };
        reset = 1'b1;
        ival0 = 1'b0; ival1 = 1'b0; ival2 = 1'b0;
        imsg0 = '0;   imsg1 = '0;   imsg2 = '0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;

        for (int i = 0; i < 8; i++) begin
            send(0, dir_v[i][64], dir_v[i][63:32], dir_v[i][31:0]);
            wait_idle(0);
        end

        // Backpressure: hold the sink off well past the response.
        sink_mode = 2;
        send(0, 1'b0, 32'd3, 32'd5);
        repeat (16) @(posedge clk);
        #1;
        sink_mode = 0;
        wait_idle(0);

        // Reset while iterating; the transaction must vanish.
        send(0, 1'b0, 32'd6, 32'hFF);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        send(0, 1'b0, 32'd2, 32'd2);
        wait_idle(0);

        sink_mode = 1;
        for (int s = 0; s < 3; s++) begin
            repeat (40) send(s, 1'($urandom_range(0, 1)), pick(nb(s)), pick(nb(s)));
            wait_idle(s);
        end
        sink_mode = 0;
        fin_req = 1'b1;
        repeat (10) @(posedge clk);
    end

endmodule

// File: doc/lab1_imul_int_mul_param.md
# lab1_imul_int_mul_param

Parametrised, variable-latency iterative integer multiplier with selectable signed/unsigned mode and a full double-width product. It replaces the fixed 32-bit, fixed-latency shift-add multiplier in the lab1_imul library. It sits behind the same val/rdy stream interface, so it drops into the same test harnesses and processor-side wrappers. Latency depends on the operand: iteration stops as soon as the remaining multiplier bits are all zero.

## Interface
- p_nbits, 32: operand width N; must be ≥ 2; the product is 2N bits.
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- istream_val  in  1  request valid.
- istream_rdy  out  1  request ready.
- istream_msg  in  2N+1  bit[2N] = signed mode (1 = two's complement); bits[2N-1:N] = a; bits[N-1:0] = b.
- ostream_val  out  1  response valid.
- ostream_rdy  in  1  response ready.
- ostream_msg  out  2N  full product a*b; interpreted as signed when the request was signed.

One clock; reset is synchronous and active-high.

## Operation
- FSM states and transitions:
  - IDLE -> CALC on istream_val & istream_rdy.
  - CALC -> DONE when the b register == 0.
  - DONE -> IDLE on ostream_val & ostream_rdy.
- Outputs are decoded from state:
  - istream_rdy = (state==IDLE) & !reset.
  - ostream_val = (state==DONE).
  - ostream_msg = result register, always driven.
- Accept (IDLE with handshake):
  - Unsigned mode: areg = zero-extend(a) to 2N bits; breg = b.
  - Signed mode: areg = zero-extend(|a|); breg = |b|. Magnitudes are taken as N-bit unsigned, so -2^(N-1) gives magnitude 2^(N-1).
  - neg = signed & (a[N-1] ^ b[N-1]).
  - result = 0.
- CALC, per cycle, when breg != 0:
  - If breg[0], then result += areg (modulo 2^2N).
  - areg <<= 1 (2N bits); breg >>= 1 (logical).
- CALC, cycle with breg == 0:
  - result = neg ? -result (two's complement, 2N bits) : result.
  - Go to DONE.
- DONE: all registers hold and ostream_msg is stable until the handshake.
- An iteration counter (width clog2(N+2)) clears on accept and increments in CALC. Reaching N+1 forces CALC -> DONE as a safety guard; it is never reached for legal operation. Verification asserts the counter never exceeds N+1.
- Reset, including mid-CALC or mid-DONE:
  - state = IDLE; result, areg, breg, neg, counter = 0.
  - The in-flight transaction is discarded and no response is produced.

## Timing
- Reset values during and after reset: istream_rdy = 0 while reset is high, then 1 in the first cycle after reset; ostream_val = 0; ostream_msg = 0.
- Let k = bit length of breg at accept (index of the highest set bit + 1; k = 0 if breg = 0).
- Latency: request handshake in cycle t gives CALC cycles t+1 .. t+k+1 and ostream_val first high in cycle t+k+2.
  - Minimum: b = 0 gives t+2.
  - Maximum unsigned: t+N+2.
  - Maximum signed: t+N+1, except |b| = 2^(N-1) gives t+N+2.
- One transaction in flight; istream_rdy = 0 from cycle t+1 until the cycle after the response handshake.
- Response handshake in cycle d gives IDLE in d+1; a new request can be accepted in d+1, not in d.
- ostream_rdy low in DONE: stall indefinitely with ostream_msg unchanged.
- istream_val outside IDLE is ignored.
- istream_msg is sampled only in the accept cycle and may change afterwards.

## Test plan
- Unsigned, N=32: a=3, b=5 accepted at t -> ostream_msg=0x0000000000000F with ostream_val first at t+5; 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFE00000001 at t+34.
- Signed, N=32:
  - -3*5 -> 0xFFFFFFFFFFFFFFF1.
  - 7*-1 -> 0xFFFFFFFFFFFFFFF9.
  - -2^31*-2^31 -> 0x4000000000000000 at t+34.
  - -1*-1 -> 0x1.
- b=0 and a=0 cases: a=0x1234, b=0 -> 0 at t+2; a=0, b=0x80000000 (unsigned) -> 0 at t+34.
- Backpressure: hold ostream_rdy=0 for 10 cycles in DONE -> ostream_val stays 1, msg stable, istream_rdy stays 0; release -> istream_rdy=1 the next cycle; then run back-to-back requests with random sink delays and check them against a golden model.
- Reset mid-CALC (a=6, b=0xFF, reset at t+3) -> ostream_val never rises; istream_rdy=1 the cycle after reset drops; a following 2*2 returns 4.
- Parameter sweep: p_nbits=8 and 16 with random signed/unsigned operands, including -2^(N-1) and all-ones -> product and latency match the formulas above.
